// File: rtl/frame_buffer_streamer.sv
// Streams one SRAM-resident frame as 8-bit pixels, four per 32-bit word, LSB first.
// Optional FRAME_STREAMER_ERR_EN adds a sticky err flag for unsolicited read beats.
module frame_buffer_streamer #(
    parameter int          N_PIXEL    = 480000,
    parameter logic [17:0] BASE_ADDR  = 18'd0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        start_ack,
    output logic        done,
    input  logic        done_ack,
    output logic [17:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    input  logic        pixel_ready
`ifdef FRAME_STREAMER_ERR_EN
    ,
    output logic        err
`endif
);
    localparam int NW  = N_PIXEL / 4;
    localparam int WW  = $clog2(NW + 1);
    localparam int PCW = $clog2(N_PIXEL + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q;
    logic [17:0]    addr_q;
    logic           addr_valid_q;
    logic           start_ack_q;
    logic           done_q;
    logic           pixel_valid_q;
    logic [7:0]     pixel_q;
    logic [WW-1:0]  issued_q;
    logic [PCW-1:0] pix_cnt_q;
    logic [CW-1:0]  outst_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [1:0]     sel_q;
    logic [31:0]    mem_q [FIFO_DEPTH];

    logic           addr_fire;
    logic           push;
    logic           load;
    logic           pop;
    logic           pix_fire;
    logic           last_addr;
    logic           last_pix;
    logic [CW:0]    credit_d;
    logic           more_d;

    assign addr_fire = addr_valid_q & addr_ready;
    assign push      = data_valid & (outst_q != '0);
    assign pix_fire  = pixel_valid_q & pixel_ready;
    assign load      = (count_q != '0) & (~pixel_valid_q | pixel_ready);
    assign pop       = load & (sel_q == 2'd3);
    assign last_addr = issued_q == WW'(NW - 1);
    assign last_pix  = pix_cnt_q == PCW'(N_PIXEL - 1);

    // A returning beat moves one credit from outstanding to the FIFO,
    // so only issue and pop change the total.
    assign credit_d = {1'b0, outst_q} + {1'b0, count_q}
                    + (CW+1)'(addr_fire) - (CW+1)'(pop);
    assign more_d   = ((issued_q + WW'(addr_fire)) < WW'(NW))
                    & (credit_d < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= BASE_ADDR;
            addr_valid_q  <= 1'b0;
            start_ack_q   <= 1'b0;
            done_q        <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_q       <= 8'd0;
            issued_q      <= '0;
            pix_cnt_q     <= '0;
            outst_q       <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sel_q         <= 2'd0;
        end else begin
            start_ack_q <= 1'b0;
            outst_q     <= outst_q + CW'(addr_fire) - CW'(push);
            count_q     <= count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (load) begin
                pixel_q       <= mem_q[rd_ptr_q][{sel_q, 3'b000} +: 8];
                pixel_valid_q <= 1'b1;
                sel_q         <= sel_q + 2'd1;
            end else if (pixel_ready) begin
                pixel_valid_q <= 1'b0;
            end
            if (pix_fire) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        start_ack_q  <= 1'b1;
                        addr_valid_q <= 1'b1;
                        addr_q       <= BASE_ADDR;
                        issued_q     <= '0;
                        pix_cnt_q    <= '0;
                    end
                end
                RUN: begin
                    if (addr_fire) begin
                        addr_q   <= addr_q + 18'd1;
                        issued_q <= issued_q + 1'b1;
                        if (last_addr) begin
                            state_q <= DRAIN;
                        end
                    end
                    addr_valid_q <= (addr_valid_q & ~addr_ready) | more_d;
                end
                DRAIN: begin
                    if (pix_fire && last_pix) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FRAME_STREAMER_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (data_valid && outst_q == '0) begin
            err_q <= 1'b1;
        end else if (state_q == IDLE && start) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`endif

    assign start_ack   = start_ack_q;
    assign done        = done_q;
    assign addr        = addr_q;
    assign addr_valid  = addr_valid_q;
    assign data_ready  = 1'b1;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_frame_buffer_streamer.sv
// Bench for frame_buffer_streamer: SRAM responder, frame-level reference model
// and directed scenarios (wrap, stall, addr backpressure, done handshake, reset).
module tb_frame_buffer_streamer;
    localparam int          NPIX = 16;
    localparam int          NWRD = NPIX / 4;
    localparam logic [17:0] BASE = 18'h3FFFE;

    logic        clock;
    logic        reset;
    logic        start;
    logic        start_ack;
    logic        done;
    logic        done_ack;
    logic [17:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        pixel_ready;
`ifdef FRAME_STREAMER_ERR_EN
    logic        err;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic        tog = 1'b0;
    logic        lmode = 1'b0;
    int          inj_req = 0;
    int          inj_seen = 0;
    logic [31:0] rq[$];
    int          rdue[$];
    logic [17:0] addr_log[$];
    logic [7:0]  pixel_log[$];
    int          ack_cnt = 0;

    frame_buffer_streamer #(
        .N_PIXEL(NPIX),
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .start_ack(start_ack),
        .done(done),
        .done_ack(done_ack),
        .addr(addr),
        .addr_valid(addr_valid),
        .addr_ready(addr_ready),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .pixel(pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
`ifdef FRAME_STREAMER_ERR_EN
        ,
        .err(err)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    function automatic logic [31:0] word_of(int i);
        return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    function automatic logic [7:0] exp_pix(int k);
        logic [31:0] w;
        w = word_of(k / 4);
        return 8'(w >> (8 * (k % 4)));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // addr_ready driver: constant 1, or toggling every cycle
    initial begin
        addr_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            addr_ready = tog ? ~addr_ready : 1'b1;
        end
    end

    // SRAM responder: fixed latency, word 3 optionally delayed
    initial begin
        logic [17:0] idx;
        data_valid = 1'b0;
        data = 32'd0;
        forever begin
            @(negedge clock);
            if (addr_valid === 1'b1 && addr_ready) begin
                idx = addr - BASE;
                rq.push_back(word_of(int'(idx)));
                rdue.push_back(cyc + ((lmode && idx == 18'd3) ? 14 : 2));
            end
            @(posedge clock);
            #1;
            if (inj_req != inj_seen) begin
                inj_seen = inj_req;
                data = 32'hDEADBEEF;
                data_valid = 1'b1;
            end else if (rdue.size() > 0 && rdue[0] <= cyc) begin
                data = rq.pop_front();
                void'(rdue.pop_front());
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end
    end

    // Frame-level reference model and per-cycle compare
    initial begin
        logic        seen = 1'b0;
        logic        rst_chk = 1'b0;
        logic        m_busy = 1'b0;
        logic        m_done = 1'b0;
        logic        m_ack = 1'b0;
        int          m_words = 0;
        int          m_pix = 0;
        logic [17:0] m_addr = BASE;
        logic        p_av = 1'b0;
        logic        p_ar = 1'b0;
        logic [17:0] p_addr = '0;
        logic        p_pv = 1'b0;
        logic        p_pr = 1'b0;
        logic [7:0]  p_pix = '0;
        forever begin
            @(negedge clock);
            if (rst_chk) begin
                check("rst_start_ack", start_ack, 0);
                check("rst_done", done, 0);
                check("rst_addr_valid", addr_valid, 0);
                check("rst_addr", addr, BASE);
                check("rst_pixel_valid", pixel_valid, 0);
                check("rst_pixel", pixel, 0);
                rst_chk = 1'b0;
            end else if (seen) begin
                check("start_ack", start_ack, m_ack);
                check("done", done, m_done);
                check("data_ready", data_ready, 1);
                if (m_ack) begin
                    check("first_addr_valid", addr_valid, 1);
                    check("first_addr", addr, BASE);
                end
                if (p_av && !p_ar) begin
                    check("addr_valid_hold", addr_valid, 1);
                    check("addr_hold", addr, p_addr);
                end
                if (p_pv && !p_pr) begin
                    check("pixel_valid_hold", pixel_valid, 1);
                    check("pixel_hold", pixel, p_pix);
                end
                if (m_words == NWRD) begin
                    check("addr_valid_after_last", addr_valid, 0);
                end
            end
            if (start_ack === 1'b1) ack_cnt++;
            if (reset) begin
                seen = 1'b1;
                rst_chk = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_ack = 1'b0;
                m_words = 0;
                m_pix = 0;
                p_av = 1'b0;
                p_pv = 1'b0;
                continue;
            end
            if (!seen) continue;
            m_ack = 1'b0;
            if (m_done && done_ack) begin
                m_done = 1'b0;
            end else if (!m_busy && !m_done && start) begin
                m_ack = 1'b1;
                m_busy = 1'b1;
                m_words = 0;
                m_pix = 0;
                m_addr = BASE;
            end
            if (addr_valid && addr_ready) begin
                if (!m_busy) begin
                    check("addr_valid_outside_frame", addr_valid, 0);
                end else begin
                    check("addr", addr, m_addr);
                    addr_log.push_back(addr);
                    m_addr = m_addr + 18'd1;
                    m_words++;
                end
            end
            if (pixel_valid && pixel_ready) begin
                if (!m_busy) begin
                    check("pixel_valid_outside_frame", pixel_valid, 0);
                end else begin
                    check("pixel", pixel, exp_pix(m_pix));
                    pixel_log.push_back(pixel);
                    m_pix++;
                    if (m_pix == NPIX) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
            p_av = addr_valid;
            p_ar = addr_ready;
            p_addr = addr;
            p_pv = pixel_valid;
            p_pr = pixel_ready;
            p_pix = pixel;
        end
    end

    task automatic start_frame();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
        check("done_timeout", done, 1);
    endtask

    task automatic ack_done();
        done_ack = 1'b1;
        step(1);
        done_ack = 1'b0;
        check("done_clear", done, 0);
    endtask

    // Literal expectations: wrapped address sequence and pixels 0x00..0x0F
    task automatic check_frame(string tag, int a0, int p0);
        logic [17:0] ea [4];
        ea = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        check({tag, "_n_addr"}, addr_log.size() - a0, 4);
        check({tag, "_n_pix"}, pixel_log.size() - p0, 16);
        for (int i = 0; i < 4 && a0 + i < addr_log.size(); i++) begin
            check({tag, "_addr_lit"}, addr_log[a0+i], ea[i]);
        end
        for (int i = 0; i < 16 && p0 + i < pixel_log.size(); i++) begin
            check({tag, "_pix_lit"}, pixel_log[p0+i], i);
        end
    endtask

    initial begin
        int a0;
        int p0;
        int k0;
        int n;
        reset = 1'b1;
        start = 1'b0;
        done_ack = 1'b0;
        pixel_ready = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // 1: plain frame across the address wrap
        a0 = addr_log.size();
        p0 = pixel_log.size();
        k0 = ack_cnt;
        start_frame();
        check("t1_start_ack", start_ack, 1);
        check("t1_addr", addr, 18'h3FFFE);
        wait_done(300);
        check_frame("t1", a0, p0);
        check("t1_ack_count", ack_cnt - k0, 1);
        ack_done();
        step(2);

        // 2: output stalled for 50 cycles
        pixel_ready = 1'b0;
        a0 = addr_log.size();
        p0 = pixel_log.size();
        start_frame();
        step(50);
        check("t2_addr_count", addr_log.size() - a0, 4);
        check("t2_addr_valid_off", addr_valid, 0);
        pixel_ready = 1'b1;
        wait_done(300);
        check_frame("t2", a0, p0);
        ack_done();
        step(2);

        // 3: addr_ready toggling
        tog = 1'b1;
        a0 = addr_log.size();
        p0 = pixel_log.size();
        start_frame();
        wait_done(300);
        tog = 1'b0;
        check_frame("t3", a0, p0);
        ack_done();
        step(2);

        // 4: done held, then ack with a simultaneous (ignored) start
        a0 = addr_log.size();
        p0 = pixel_log.size();
        start_frame();
        wait_done(300);
        check_frame("t4", a0, p0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t4_done_hold", done, 1);
        end
        done_ack = 1'b1;
        start = 1'b1;
        step(1);
        done_ack = 1'b0;
        start = 1'b0;
        check("t4_done_clear", done, 0);
        step(1);
        check("t4_no_start_ack", start_ack, 0);
        step(1);
        start_frame();
        check("t4_restart_ack", start_ack, 1);
        check("t4_restart_addr", addr, 18'h3FFFE);
        check("t4_restart_av", addr_valid, 1);
        wait_done(300);
        ack_done();
        step(2);

        // 5: reset mid-frame with a word still in flight
        lmode = 1'b1;
        p0 = pixel_log.size();
        start_frame();
        n = 0;
        while (pixel_log.size() - p0 < 6 && n < 200) begin
            step(1);
            n++;
        end
        check("t5_six_pixels", (pixel_log.size() - p0) >= 6, 1);
        check("t5_in_flight", rq.size() > 0, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_rst_av", addr_valid, 0);
        check("t5_rst_pv", pixel_valid, 0);
        check("t5_rst_addr", addr, BASE);
        n = 0;
        while ((rq.size() > 0 || data_valid) && n < 60) begin
            step(1);
            n++;
        end
        check("t5_late_beat_timeout", rq.size(), 0);
        step(2);
        check("t5_idle_pv", pixel_valid, 0);
`ifdef FRAME_STREAMER_ERR_EN
        check("t5_err_late", err, 1);
`endif
        lmode = 1'b0;
        a0 = addr_log.size();
        p0 = pixel_log.size();
        start_frame();
        wait_done(300);
        check_frame("t5", a0, p0);
        ack_done();
        step(2);

`ifdef FRAME_STREAMER_ERR_EN
        // 6: unsolicited beat in IDLE
        check("t6_err_clear", err, 0);
        inj_req++;
        step(2);
        check("t6_err_set", err, 1);
        step(3);
        check("t6_err_hold", err, 1);
        start_frame();
        check("t6_err_start_clear", err, 0);
        wait_done(300);
        ack_done();
        step(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/frame_buffer_streamer.md
Name: frame_buffer_streamer

Overview:
Streams one stored frame out of SRAM as a serial 8-bit grayscale pixel stream. It issues word addresses on a spare arbiter read port and unpacks each returned 32-bit word into four pixels. It is the read-side counterpart of the image buffer writer, which packs pixels four-per-word. It feeds downstream processing stages such as the down/up samplers or an overlay path, and follows the same start/done handshake protocol used by the swap controller.

Parameters:
N_PIXEL, 480000, pixels per frame; must be a multiple of 4, with N_PIXEL/4 <= 2^18
BASE_ADDR, 18'd0, SRAM word address of pixel 0
FIFO_DEPTH, 8, word FIFO depth; must be a power of 2 and >= 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request from the controller (level)
start_ack  out  1  one-cycle pulse when the request is accepted
done  out  1  frame complete; held high until done_ack
done_ack  in  1  controller acknowledge of done
addr  out  18  SRAM word address to the arbiter read port
addr_valid  out  1  addr is valid
addr_ready  in  1  arbiter accepts addr
data  in  32  returned read word
data_valid  in  1  data is valid
data_ready  out  1  constant 1; space is guaranteed by credits
pixel  out  8  output pixel
pixel_valid  out  1  pixel is valid
pixel_ready  in  1  downstream accepts pixel

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values: start_ack=0, done=0, addr_valid=0, addr=BASE_ADDR, pixel_valid=0, pixel=0. FIFO, counters and credits are cleared. State = IDLE.
- A transfer occurs only on a cycle where both valid and ready are high. An asserted valid is never dropped, and its payload is held stable until the transfer.
- IDLE: when start=1 is sampled, the next cycle has start_ack=1 for one cycle, addr_valid=1 and addr=BASE_ADDR. State goes to RUN.
- RUN, address issue:
  - addr_valid=1 only while issued_words < N_PIXEL/4 and (outstanding + fifo_count) < FIFO_DEPTH.
  - Each accepted address increments addr by 1, modulo 2^18 (wraps at 18'h3FFFF to 0), and increments outstanding.
  - When the last address is accepted, go to DRAIN.
- Data return:
  - Each data_valid beat pushes the word into the FIFO and decrements outstanding.
  - The FIFO can never overflow because of the credit rule.
  - A data_valid beat with outstanding=0 is discarded.
- Unpack: pixels are emitted LSB first, i.e. data[7:0], [15:8], [23:16], [31:24].
  - The word is popped when its 4th byte transfers.
  - Throughput is 1 pixel/cycle while pixel_ready=1 and the FIFO is non-empty.
  - The first pixel of a word is valid no earlier than 1 cycle after that word's data_valid beat (registered output).
  - pixel_ready=0 stalls the output; the FIFO fills and address issue throttles.
- DRAIN: when the N_PIXEL-th pixel transfers, go to DONE on the next cycle.
- DONE: done=1 until done_ack=1 is sampled. The next cycle has done=0 and state IDLE. If done_ack and start are both high in the same cycle, start is ignored; a new start is sampled only in IDLE.
- start while not IDLE is ignored, with no start_ack.
- done_ack while not DONE is ignored.
- Reset mid-frame aborts immediately and returns all outputs to their reset values. Late data beats arriving after reset see outstanding=0 and are discarded.
- Counters are sized for N_PIXEL/4 and FIFO_DEPTH with no overflow: word count uses clog2(N_PIXEL/4+1) bits; outstanding uses clog2(FIFO_DEPTH+1) bits.

Optional Feature:
FRAME_STREAMER_ERR_EN:
- Defined: adds output port err (1 bit, reset 0). err is sticky high on the cycle after an unsolicited data beat (data_valid=1 with outstanding=0). It clears only on reset or when a new start is accepted.
- Undefined: the port is absent, and unsolicited beats are silently discarded.

Test Plan (bench configuration N_PIXEL=16, BASE_ADDR=18'h3FFFE, FIFO_DEPTH=4 unless stated):
1. start=1, addr_ready=1, data returned 2 cycles after each address with words 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, pixel_ready=1 -> start_ack pulses once; addrs are 3FFFE, 3FFFF, 00000, 00001 (wrap); pixels 0x00..0x0F appear in order; done=1 after the 16th pixel.
2. pixel_ready=0 held for 50 cycles -> exactly 4 addresses issued, addr_valid=0 thereafter; no data lost after release; pixels still 0x00..0x0F.
3. addr_ready toggling 1/0 every cycle -> addr held stable while addr_ready=0; 4 unique addresses total; output identical to test 1.
4. done held for 10 cycles with done_ack=0 -> done stays 1; done_ack=1 for 1 cycle -> done=0 next cycle; start issued 2 cycles later -> new start_ack and addr=3FFFE.
5. reset asserted after 6 pixels, with one word in flight -> next cycle all outputs at reset values; the late data beat is discarded; a following full frame outputs 0x00..0x0F correctly.
6. (ERR_EN) data_valid=1 injected in IDLE -> err=1 next cycle and held; accepted start -> err=0.
